// File: rtl/uart_receiver.sv
// UART 8N1 receiver: two-flop input synchroniser, mid-bit sampling FSM,
// registered byte output with one-cycle done / frame-error pulses.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       o_Rx_Active
);

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_BIT = 8'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        s_WAIT_HIGH,
        s_IDLE,
        s_START,
        s_DATA,
        s_STOP
    } state_t;

    state_t     state_q, state_d;
    logic       sync1_q, rx_s_q;
    logic [7:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] dout_q, dout_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
    logic       active_q, active_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= s_WAIT_HIGH;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            dout_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sync1_q   <= rx;
            rx_s_q    <= sync1_q;
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        ferr_d    = 1'b0;
        active_d  = active_q;

        case (state_q)
            s_WAIT_HIGH: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                active_d  = 1'b0;
                if (rx_s_q) state_d = s_IDLE;
            end
            s_IDLE: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d  = s_START;
                    active_d = 1'b1;
                end
            end
            s_START: begin
                // Re-check at mid start bit so short glitches are rejected silently.
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = s_DATA;
                    end else begin
                        state_d  = s_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            s_DATA: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d          = '0;
                    shreg_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = s_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            s_STOP: begin
                if (clk_cnt_q == CNT_LAST) begin
                    clk_cnt_d = '0;
                    active_d  = 1'b0;
                    if (rx_s_q) begin
                        dout_d  = shreg_q;
                        done_d  = 1'b1;
                        state_d = s_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = s_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d   = s_WAIT_HIGH;
                clk_cnt_d = '0;
                bit_idx_d = '0;
                active_d  = 1'b0;
            end
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign o_Rx_Active  = active_q;

endmodule
